// File: rtl/key_repeat_fsm.sv
// key_repeat_fsm: turns a debounced button level into press and auto-repeat action pulses
module key_repeat_fsm #(
  parameter int INITIAL_DELAY = 15000000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter int CNT_W         = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic debounced,
  input  logic repeat_en,
  output logic pulse,
  output logic held,
  output logic repeat_active
);
  typedef enum logic [1:0] {WAIT_REL, IDLE, DELAY, REPEAT} state_t;
  localparam logic [CNT_W-1:0] ID_LAST = CNT_W'(INITIAL_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
  state_t r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx, w_cnt_inc;
  logic r_pulse, r_held, r_rep, w_pulse_nx;
  assign w_cnt_inc     = r_cnt + CNT_W'(1);
  assign pulse         = r_pulse;
  assign held          = r_held;
  assign repeat_active = r_rep;
  // next state, counter and strobe; release always beats a counter expiry
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_pulse_nx = 1'b0;
    case (r_state)
      WAIT_REL: w_state_nx = debounced ? WAIT_REL : IDLE;
      IDLE: if (debounced) begin
        w_state_nx = DELAY;
        w_cnt_nx   = '0;
        w_pulse_nx = 1'b1;
      end
      DELAY: if (!debounced) w_state_nx = IDLE;
      else if (r_cnt == ID_LAST) begin
        w_state_nx = repeat_en ? REPEAT : WAIT_REL;
        w_cnt_nx   = '0;
        w_pulse_nx = repeat_en;
      end else w_cnt_nx = w_cnt_inc;
      REPEAT: if (!debounced) w_state_nx = IDLE;
      else if (!repeat_en) w_state_nx = WAIT_REL;
      else if (r_cnt == RP_LAST) begin
        w_cnt_nx   = '0;
        w_pulse_nx = 1'b1;
      end else w_cnt_nx = w_cnt_inc;
    endcase
  end
  // state register with status flags registered alongside the state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= WAIT_REL;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
      r_held  <= 1'b0;
      r_rep   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_pulse <= w_pulse_nx;
      r_held  <= (w_state_nx == DELAY) || (w_state_nx == REPEAT);
      r_rep   <= w_state_nx == REPEAT;
    end
  end
endmodule

// File: tb/tb_key_repeat_fsm.sv
// tb_key_repeat_fsm: scoreboard bench for key_repeat_fsm using a press-age reference model
module tb_key_repeat_fsm;
  localparam int ID = 8;
  localparam int RP = 4;
  logic clk = 1'b0;
  logic reset, debounced, repeat_en;
  logic pulse, held, repeat_active;
  logic [2:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int n_pulse = 0;
  int m_mode = 0;
  int m_age = 0;
  key_repeat_fsm #(.INITIAL_DELAY(ID), .REPEAT_PERIOD(RP), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .debounced(debounced), .repeat_en(repeat_en),
    .pulse(pulse), .held(held), .repeat_active(repeat_active)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got %0h want %0h", tag, $time, obs, exp);
    end
  endtask
  task automatic step(input logic d, input logic re, input logic rst);
    logic [2:0] e;
    reset = rst;
    debounced = d;
    repeat_en = re;
    e = 3'b000;
    if (rst) m_mode = 0;
    else if (m_mode == 0) begin
      if (!d) m_mode = 1;
    end else if (m_mode == 1) begin
      if (d) begin
        m_mode = 2;
        m_age = 0;
        e = 3'b110;
      end
    end else if (!d) m_mode = 1;
    else begin
      m_age++;
      if (m_age < ID) e = 3'b010;
      else if (!re) m_mode = 0;
      else e = {((m_age - ID) % RP) == 0, 2'b11};
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (pulse) n_pulse++;
    chk("pulse/held/rep", {29'd0, pulse, held, repeat_active}, {29'd0, exp_q.pop_front()});
  endtask
  task automatic run(input logic d, input logic re, input logic rst, input int n);
    for (int i = 0; i < n; i++) step(d, re, rst);
  endtask
  initial begin
    reset = 1'b1;
    debounced = 1'b0;
    repeat_en = 1'b1;
    run(0, 1, 1, 2);
    run(0, 1, 0, 2);
    n_pulse = 0;
    run(1, 1, 0, 20);
    run(0, 1, 0, 3);
    chk("s1_pulses", n_pulse, 4);
    n_pulse = 0;
    run(1, 1, 0, 3);
    run(0, 1, 0, 2);
    chk("tap_pulses", n_pulse, 1);
    n_pulse = 0;
    run(1, 0, 0, 30);
    run(0, 0, 0, 1);
    run(1, 0, 0, 3);
    run(0, 0, 0, 2);
    chk("norep_pulses", n_pulse, 2);
    n_pulse = 0;
    run(1, 1, 1, 2);
    run(1, 1, 0, 5);
    chk("held_reset_pulses", n_pulse, 0);
    run(0, 1, 0, 1);
    run(1, 1, 0, 3);
    run(0, 1, 0, 2);
    chk("repress_pulses", n_pulse, 1);
    n_pulse = 0;
    run(1, 1, 0, 11);
    chk("pre_reset_pulses", n_pulse, 2);
    n_pulse = 0;
    run(1, 1, 1, 1);
    chk("reset_flags", {29'd0, pulse, held, repeat_active}, 32'd0);
    run(1, 1, 0, 10);
    chk("post_reset_pulses", n_pulse, 0);
    run(0, 1, 0, 2);
    n_pulse = 0;
    run(1, 1, 0, 5);
    run(0, 1, 0, 1);
    run(1, 1, 0, 12);
    run(0, 1, 0, 2);
    chk("rerepress_pulses", n_pulse, 3);
    n_pulse = 0;
    run(1, 1, 0, 12);
    run(1, 0, 0, 1);
    chk("re_off_flags", {29'd0, pulse, held, repeat_active}, 32'd0);
    run(1, 1, 0, 4);
    run(0, 1, 0, 2);
    chk("re_off_pulses", n_pulse, 2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
